// File: rtl/approx_mul_pkg.sv
// Shared widths and entry types for the shared approximate/exact multiplier block.
// Imported by the multiplier core and the arbiter top level.
package approx_mul_pkg;

    localparam int MUL_W  = 8;
    localparam int PROD_W = 16;
    // Wide enough for the largest supported requester count (8).
    localparam int ID_W   = 3;
    // Partial-product columns below this weight are discarded by the approximate core.
    localparam int APPROX_DROP_COLS = 4;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            exact;
    } mul_tag_t;

    typedef struct packed {
        logic [PROD_W-1:0] z;
        mul_tag_t          tag;
    } mul_entry_t;

endpackage

// File: rtl/approx_mul8_core.sv
// Combinational 8x8 unsigned truncated multiplier: partial-product bits whose
// column weight is below APPROX_DROP_COLS are discarded, everything else is summed.
module approx_mul8_core
    import approx_mul_pkg::*;
(
    input  logic [MUL_W-1:0]  x,
    input  logic [MUL_W-1:0]  y,
    output logic [PROD_W-1:0] z
);

    localparam logic [PROD_W-1:0] KEEP_MASK = ~PROD_W'((1 << APPROX_DROP_COLS) - 1);

    logic [PROD_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int j = 0; j < MUL_W; j++) begin
            if (y[j]) begin
                acc = acc + ((PROD_W'(x) << j) & KEEP_MASK);
            end
        end
    end

    assign z = acc;

endmodule

// File: rtl/approx_mul_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier among N_REQ requesters, with a
// fixed-latency product pipeline and a credit-guarded result FIFO.
module approx_mul_arbiter
    import approx_mul_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*MUL_W-1:0]    req_x,
    input  logic [N_REQ*MUL_W-1:0]    req_y,
    input  logic [N_REQ-1:0]          req_exact,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PROD_W-1:0]         rsp_z,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic                      rsp_exact,
    output logic                      busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    grant_id;
    logic [IDW-1:0]    cand;
    logic              grant_any;
    logic              issue_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic [CW-1:0]     credits;
    logic [CW-1:0]     count;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [MUL_W-1:0]  sel_x;
    logic [MUL_W-1:0]  sel_y;
    logic              sel_exact;
    logic [PROD_W-1:0] approx_z;
    logic [PROD_W-1:0] stage0_z;
    logic [LAT-1:0]    stage_valid;
    mul_entry_t        stage_q  [LAT];
    mul_entry_t        fifo_mem [FIFO_DEPTH];
    mul_entry_t        head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Issue is also allowed at the credit limit when a FIFO slot frees this cycle.
    assign pop      = rsp_valid & rsp_ready;
    assign issue_ok = rst_n & ((credits < CW'(FIFO_DEPTH)) |
                               ((credits == CW'(FIFO_DEPTH)) & pop));

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDW'((int'(ptr) + i) % N_REQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    assign accept = grant_any & issue_ok;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_exact = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_x     = req_x[i*MUL_W +: MUL_W];
                sel_y     = req_y[i*MUL_W +: MUL_W];
                sel_exact = req_exact[i];
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
        end
    end

    approx_mul8_core u_core (
        .x (sel_x),
        .y (sel_y),
        .z (approx_z)
    );

    assign stage0_z = sel_exact ? (PROD_W'(sel_x) * PROD_W'(sel_y)) : approx_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
        end else begin
            stage_valid[0] <= accept;
            for (int i = 1; i < LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // NOTE: pipeline data carries no reset; the stage valid bits qualify it.
    always_ff @(posedge clk) begin
        if (accept) begin
            stage_q[0].z         <= stage0_z;
            stage_q[0].tag.id    <= ID_W'(grant_id);
            stage_q[0].tag.exact <= sel_exact;
        end
        for (int i = 1; i < LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
    end

    assign push = stage_valid[LAT-1];

    // Storage is cleared on reset because the head entry drives rsp_* directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= stage_q[LAT-1];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   credits <= credits + CW'(1);
                2'b01:   credits <= credits - CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign rsp_valid = (count != '0);
    assign rsp_z     = head.z;
    assign rsp_id    = IDW'(head.tag.id);
    assign rsp_exact = head.tag.exact;
    assign busy      = (|stage_valid) | rsp_valid;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed bench for approx_mul_arbiter: reset, latency, round-robin, backpressure,
// full-with-pop, approximate mode, random sweep against a scoreboard, mid-run reset.
module tb_approx_mul_arbiter;

    localparam int N_REQ      = 4;
    localparam int LAT        = 2;
    localparam int FIFO_DEPTH = 8;

    typedef struct packed {
        logic [31:0] z;
        logic [31:0] id;
        logic [31:0] ex;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*8-1:0]   req_x;
    logic [N_REQ*8-1:0]   req_y;
    logic [N_REQ-1:0]     req_exact;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_z;
    logic [1:0]           rsp_id;
    logic                 rsp_exact;
    logic                 busy;

    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    int          n_pop  = 0;
    logic [N_REQ-1:0] last_acc;
    exp_t        q[$];
    logic [3:0]  rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    approx_mul_arbiter #(
        .N_REQ      (N_REQ),
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_exact (req_exact),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_id    (rsp_id),
        .rsp_exact (rsp_exact),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Golden approximate model: exact product minus the discarded low-column terms.
    function automatic logic [31:0] approx_model(input logic [7:0] x, input logic [7:0] y);
        logic [31:0] lost;
        lost = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if ((i + j) < 4 && x[i] && y[j]) lost = lost + (32'd1 << (i + j));
            end
        end
        return 32'(x) * 32'(y) - lost;
    endfunction

    task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y, input logic ex);
        req_x[i*8 +: 8] = x;
        req_y[i*8 +: 8] = y;
        req_exact[i]    = ex;
    endtask

    // Observe handshakes just before the edge, then advance one clock.
    task automatic step();
        exp_t e;
        logic [7:0] x;
        logic [7:0] y;
        #1;
        check("ready_onehot0", 32'($onehot0(req_ready)), 1);
        last_acc = req_valid & req_ready;
        for (int i = 0; i < N_REQ; i++) begin
            if (last_acc[i]) begin
                x    = req_x[i*8 +: 8];
                y    = req_y[i*8 +: 8];
                e.z  = req_exact[i] ? 32'(x) * 32'(y) : approx_model(x, y);
                e.id = i;
                e.ex = 32'(req_exact[i]);
                q.push_back(e);
                n_acc++;
            end
        end
        if (rsp_valid && rsp_ready) begin
            check("rsp_has_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("rsp_z", 32'(rsp_z), e.z);
                check("rsp_id", 32'(rsp_id), e.id);
                check("rsp_exact", 32'(rsp_exact), e.ex);
            end
            n_pop++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (last_acc[i]) req_x[i*8 +: 8] = req_x[i*8 +: 8] + 8'd1;
        end
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 64 && (q.size() != 0 || busy); n++) step();
        check("drain_empty", 32'(q.size()), 0);
        check("drain_idle", 32'(busy), 0);
        rsp_ready = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_z"}, 32'(rsp_z), 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_exact"}, 32'(rsp_exact), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_exact = '0;
        rsp_ready = 1'b0;
        last_acc  = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Round-robin with every requester active: grants 0,1,2,3,0.
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'(10 + i), 8'(3 + i), i[0]);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(rr_exp[k]));
            step();
        end
        drain();

        // Single exact request from requester 2: 200*150 after two edges.
        set_req(2, 8'd200, 8'd150, 1'b1);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'(4'b0100));
        step();
        req_valid = '0;
        #1;
        check("lat_k_valid", 32'(rsp_valid), 0);
        check("lat_k_busy", 32'(busy), 1);
        step();
        #1;
        check("lat_k1_valid", 32'(rsp_valid), 0);
        step();
        #1;
        check("lat_k2_valid", 32'(rsp_valid), 1);
        check("single_z", 32'(rsp_z), 30000);
        check("single_id", 32'(rsp_id), 2);
        check("single_exact", 32'(rsp_exact), 1);
        drain();

        // Backpressure: exactly FIFO_DEPTH accepts, then no grant.
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'(16 * i + 1), 8'(i + 5), (i % 2) == 0);
        req_valid = '1;
        rsp_ready = 1'b0;
        n_acc = 0;
        repeat (14) step();
        #1;
        check("bp_accepts", 32'(n_acc), FIFO_DEPTH);
        check("bp_ready_zero", 32'(req_ready), 0);
        check("bp_rsp_valid", 32'(rsp_valid), 1);

        // Full FIFO with a simultaneous pop: exactly one accept, occupancy unchanged.
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        check("full_pop_ready", 32'(req_ready), 32'(4'b0100));
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("full_after_pop_ready", 32'(req_ready), 0);
        req_valid = '0;
        repeat (3) step();
        n_pop = 0;
        drain();
        check("full_pop_drain_count", 32'(n_pop), FIFO_DEPTH);

        // Approximate mode at the operand maximum: 65025 - 49 = 64976.
        set_req(0, 8'd255, 8'd255, 1'b0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step();
        #1;
        check("approx_valid", 32'(rsp_valid), 1);
        check("approx_z", 32'(rsp_z), 64976);
        check("approx_exact", 32'(rsp_exact), 0);
        drain();

        // Random sweep of both modes; requesters only change after acceptance.
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        rsp_ready = 1'b1;
        for (int n = 0; n < 80; n++) begin
            step();
            for (int i = 0; i < N_REQ; i++) begin
                if (!req_valid[i] || last_acc[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    set_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                            1'($urandom_range(0, 1)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        // Reset with three results buffered and two in flight.
        for (int i = 0; i < N_REQ; i++) set_req(i, 8'(20 + i), 8'(7 + i), 1'b1);
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (5) step();
        check("pre_reset_valid", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_reset_ptr0", 32'(req_ready), 32'(4'b0001));
        check("post_reset_valid", 32'(rsp_valid), 0);
        req_valid = '0;
        repeat (4) step();
        check("post_reset_no_stale", 32'(rsp_valid), 0);
        check("post_reset_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
